// File: rtl/fftdemo_pkg.sv
// Shared definitions for the FFT demo filter datapath: default widths and
// the coefficient loader state encoding.
package fftdemo_pkg;

  localparam int DEF_IW      = 16;
  localparam int DEF_TW      = 12;
  localparam int DEF_LGNTAPS = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_READY = 3'd4
  } ld_state_t;

  function automatic logic state_is_busy(input ld_state_t s);
    return (s == ST_FLUSH) || (s == ST_FETCH) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/rate_guard.sv
// Sample-rate guard: counts cycles since the last accepted sample and raises
// a sticky overrun flag when samples arrive closer than MIN_GAP cycles.
module rate_guard #(
  parameter int MIN_GAP = 17
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_arm,
  input  logic i_active,
  input  logic i_ce,
  input  logic i_clear,
  output logic o_overrun
);

  localparam int CW = $clog2(MIN_GAP + 1);
  localparam logic [CW-1:0] GAP_MAX  = CW'(MIN_GAP);
  localparam logic [CW-1:0] GAP_LAST = CW'(MIN_GAP - 1);

  logic [CW-1:0] gap_reg;

  // gap_reg holds (cycles since last sample - 1), so a sample exactly
  // MIN_GAP cycles after the previous one sees gap_reg == MIN_GAP-1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      gap_reg   <= GAP_MAX;
      o_overrun <= 1'b0;
    end else begin
      if (i_clear)
        o_overrun <= 1'b0;
      if (i_arm) begin
        gap_reg <= GAP_MAX;
      end else if (i_active) begin
        if (i_ce) begin
          gap_reg <= '0;
          if (gap_reg < GAP_LAST)
            o_overrun <= 1'b1;
        end else if (gap_reg != GAP_MAX) begin
          gap_reg <= gap_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fil_coeff_loader.sv
// Loads one bank of filter taps from coefficient memory into the filter and
// gates the upstream sample stream until the filter holds a complete tap set.
module fil_coeff_loader
  import fftdemo_pkg::*;
#(
  parameter int IW      = DEF_IW,
  parameter int TW      = DEF_TW,
  parameter int LGNTAPS = DEF_LGNTAPS,
  parameter int LGBANKS = 2,
  parameter int MIN_GAP = (1 << LGNTAPS) + 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_load_req,
  input  logic [LGBANKS-1:0]         i_bank,
  output logic [LGBANKS+LGNTAPS-1:0] o_rd_addr,
  input  logic [TW-1:0]              i_rd_data,
  output logic                       o_fil_reset,
  output logic                       o_wr_tap,
  output logic [TW-1:0]              o_tap,
  input  logic                       i_ce,
  input  logic [IW-1:0]              i_sample,
  output logic                       o_ce,
  output logic [IW-1:0]              o_sample,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_dropped,
  output logic                       o_overrun
);

  localparam logic [LGNTAPS-1:0] IDX_LAST = '1;

  ld_state_t            state_reg;
  logic [LGBANKS-1:0]   bank_reg;
  logic [LGNTAPS-1:0]   idx_reg;
  logic [LGNTAPS-1:0]   idx_next;
  logic                 load_accept;
  logic                 in_ready;

  assign in_ready    = (state_reg == ST_READY);
  assign load_accept = i_load_req && ((state_reg == ST_IDLE) || in_ready);
  assign idx_next    = idx_reg + 1'b1;

  // Memory read data is already registered; o_tap only masks it to zero
  // outside the write strobe so it lines up with o_wr_tap without a stall.
  assign o_tap = o_wr_tap ? i_rd_data : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg   <= ST_IDLE;
      bank_reg    <= '0;
      idx_reg     <= '0;
      o_rd_addr   <= '0;
      o_fil_reset <= 1'b1;
      o_wr_tap    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_ce        <= 1'b0;
      o_sample    <= '0;
      o_dropped   <= 1'b0;
    end else begin
      o_fil_reset <= 1'b0;
      o_done      <= 1'b0;
      o_wr_tap    <= (state_reg == ST_FETCH);
      o_ce        <= i_ce && in_ready;
      if (i_ce && in_ready)
        o_sample <= i_sample;

      if (load_accept)
        o_dropped <= 1'b0;
      if (i_ce && !in_ready)
        o_dropped <= 1'b1;

      case (state_reg)
        ST_IDLE, ST_READY: begin
          if (load_accept) begin
            bank_reg    <= i_bank;
            state_reg   <= ST_FLUSH;
            o_fil_reset <= 1'b1;
            o_busy      <= 1'b1;
          end
        end
        ST_FLUSH: begin
          idx_reg   <= '0;
          o_rd_addr <= {bank_reg, {LGNTAPS{1'b0}}};
          state_reg <= ST_FETCH;
        end
        ST_FETCH: begin
          // Index parks at the last tap instead of wrapping into a second pass.
          if (idx_reg == IDX_LAST) begin
            state_reg <= ST_DRAIN;
          end else begin
            idx_reg   <= idx_next;
            o_rd_addr <= {bank_reg, idx_next};
          end
        end
        ST_DRAIN: begin
          state_reg <= ST_READY;
          o_done    <= 1'b1;
          o_busy    <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          o_busy    <= state_is_busy(ST_IDLE);
        end
      endcase
    end
  end

  rate_guard #(
    .MIN_GAP (MIN_GAP)
  ) u_rate_guard (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_arm     (!in_ready),
    .i_active  (in_ready),
    .i_ce      (i_ce),
    .i_clear   (load_accept),
    .o_overrun (o_overrun)
  );

endmodule

// File: tb/tb_fil_coeff_loader.sv
// Directed bench for fil_coeff_loader with a 16-tap, 4-bank configuration.
module tb_fil_coeff_loader;

  localparam int IW      = 16;
  localparam int TW      = 12;
  localparam int LGNTAPS = 4;
  localparam int LGBANKS = 2;
  localparam int N       = 16;
  localparam int MIN_GAP = 17;
  localparam int AW      = LGBANKS + LGNTAPS;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_load_req = 1'b0;
  logic [LGBANKS-1:0] i_bank = '0;
  logic [AW-1:0]      o_rd_addr;
  logic [TW-1:0]      i_rd_data;
  logic               o_fil_reset;
  logic               o_wr_tap;
  logic [TW-1:0]      o_tap;
  logic               i_ce = 1'b0;
  logic [IW-1:0]      i_sample = '0;
  logic               o_ce;
  logic [IW-1:0]      o_sample;
  logic               o_busy;
  logic               o_done;
  logic               o_dropped;
  logic               o_overrun;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  // Coefficient memory with registered read whose contents equal the address.
  always @(posedge i_clk) i_rd_data <= TW'(o_rd_addr);

  fil_coeff_loader #(
    .IW(IW), .TW(TW), .LGNTAPS(LGNTAPS), .LGBANKS(LGBANKS), .MIN_GAP(MIN_GAP)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_load_req(i_load_req), .i_bank(i_bank),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_fil_reset(o_fil_reset),
    .o_wr_tap(o_wr_tap), .o_tap(o_tap), .i_ce(i_ce), .i_sample(i_sample),
    .o_ce(o_ce), .o_sample(o_sample), .o_busy(o_busy), .o_done(o_done),
    .o_dropped(o_dropped), .o_overrun(o_overrun)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Drives a load at cycle 0 and checks every cycle through o_done at N+3.
  // Optional side stimulus: i_ce at ce_at, a second request at req_at,
  // reset at rst_at (which ends the load early).
  task automatic run_load(input logic [LGBANKS-1:0] b, input int ce_at,
                          input int req_at, input logic [LGBANKS-1:0] req_b,
                          input int rst_at);
    int writes;
    logic [4:0] got, exp;
    logic [1:0] gf, ef;
    logic [3:0] gr;
    logic [TW-1:0] exp_tap;
    writes = 0;
    i_bank = b;
    i_load_req = 1'b1;
    for (int c = 1; c <= N + 3; c++) begin
      step();
      i_load_req = 1'b0;
      i_ce = 1'b0;
      exp = {c == 1, c <= N + 2, (c >= 3) && (c <= N + 2), c == N + 3, 1'b0};
      got = {o_fil_reset, o_busy, o_wr_tap, o_done, o_ce};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL load_ctrl bank %0d cycle %0d: {frst,busy,wr,done,ce} got %b expected %b", b, c, got, exp);
      end
      if (o_wr_tap === 1'b1) begin
        exp_tap = TW'(b * N + (c - 3));
        checks++;
        if (o_tap !== exp_tap) begin
          errors++;
          $display("FAIL load_tap bank %0d cycle %0d: got %h expected %h", b, c, o_tap, exp_tap);
        end
        writes++;
      end
      ef = {(ce_at > 0) && (c > ce_at), 1'b0};
      gf = {o_dropped, o_overrun};
      checks++;
      if (gf !== ef) begin
        errors++;
        $display("FAIL load_flags bank %0d cycle %0d: {dropped,overrun} got %b expected %b", b, c, gf, ef);
      end
      if (c == ce_at) begin
        i_ce = 1'b1;
        i_sample = 16'hBEEF;
      end
      if (c == req_at) begin
        i_load_req = 1'b1;
        i_bank = req_b;
      end
      if (c == rst_at) begin
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        gr = {o_fil_reset, o_wr_tap, o_busy, o_done};
        checks++;
        if (gr !== 4'b1000 || o_rd_addr !== '0) begin
          errors++;
          $display("FAIL mid_reset: {frst,wr,busy,done} got %b expected 1000, addr got %h expected 0", gr, o_rd_addr);
        end
        $display("load bank %0d aborted by reset after %0d writes", b, writes);
        return;
      end
    end
    checks++;
    if (writes != N) begin
      errors++;
      $display("FAIL write_count bank %0d: got %0d expected %0d", b, writes, N);
    end
    $display("load bank %0d: %0d writes, done at cycle %0d", b, writes, N + 3);
  endtask

  // Pulses i_ce for one cycle and checks the forwarded strobe and flags.
  task automatic pulse_ce(input logic [IW-1:0] s, input logic exp_ce, input logic exp_ovr);
    i_ce = 1'b1;
    i_sample = s;
    step();
    i_ce = 1'b0;
    checks++;
    if ({o_ce, o_overrun} !== {exp_ce, exp_ovr}) begin
      errors++;
      $display("FAIL sample %h: {ce,overrun} got %b%b expected %b%b", s, o_ce, o_overrun, exp_ce, exp_ovr);
    end
    if (exp_ce) begin
      checks++;
      if (o_sample !== s) begin
        errors++;
        $display("FAIL sample_data: got %h expected %h", o_sample, s);
      end
    end
    $display("sample %h: ce=%b overrun=%b dropped=%b", s, o_ce, o_overrun, o_dropped);
  endtask

  task automatic test_reset();
    logic [6:0] got;
    i_load_req = 1'b1;
    i_bank = 2'd3;
    step();
    got = {o_fil_reset, o_busy, o_wr_tap, o_ce, o_done, o_dropped, o_overrun};
    checks++;
    if (got !== 7'b1000000 || o_rd_addr !== '0 || o_tap !== '0 || o_sample !== '0) begin
      errors++;
      $display("FAIL reset_state: flags got %b expected 1000000, addr %h tap %h sample %h expected 0", got, o_rd_addr, o_tap, o_sample);
    end
    i_reset = 1'b0;
    i_load_req = 1'b0;
    step();
    checks++;
    if ({o_fil_reset, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_wins: {frst,busy} got %b%b expected 00", o_fil_reset, o_busy);
    end
    $display("reset with simultaneous load request: busy=%b", o_busy);
  endtask

  task automatic test_idle_drop();
    pulse_ce(16'h0BAD, 1'b0, 1'b0);
    checks++;
    if (o_dropped !== 1'b1) begin
      errors++;
      $display("FAIL idle_drop: dropped got %b expected 1", o_dropped);
    end
  endtask

  task automatic test_load_bank2();
    run_load(2'd2, 0, 0, 2'd0, 0);
  endtask

  task automatic test_rate();
    pulse_ce(16'h1111, 1'b1, 1'b0);
    repeat (9) step();
    pulse_ce(16'h2222, 1'b1, 1'b1);
    run_load(2'd1, 0, 0, 2'd0, 0);
    pulse_ce(16'h3333, 1'b1, 1'b0);
    repeat (16) step();
    pulse_ce(16'h4444, 1'b1, 1'b0);
    repeat (15) step();
    pulse_ce(16'h5555, 1'b1, 1'b1);
  endtask

  task automatic test_busy_drop();
    run_load(2'd1, 5, 0, 2'd0, 0);
  endtask

  task automatic test_ignore_req();
    run_load(2'd3, 0, 8, 2'd0, 0);
    step();
    checks++;
    if ({o_busy, o_wr_tap, o_fil_reset} !== 3'b000) begin
      errors++;
      $display("FAIL ignore_req_restart: {busy,wr,frst} got %b%b%b expected 000", o_busy, o_wr_tap, o_fil_reset);
    end
  endtask

  task automatic test_reset_mid();
    run_load(2'd2, 0, 0, 2'd0, 10);
    step();
    pulse_ce(16'h7777, 1'b0, 1'b0);
    checks++;
    if ({o_dropped, o_busy} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_block: {dropped,busy} got %b%b expected 10", o_dropped, o_busy);
    end
  endtask

  task automatic test_reload();
    run_load(2'd0, 0, 0, 2'd0, 0);
    pulse_ce(16'hA5A5, 1'b1, 1'b0);
    run_load(2'd1, 12, 0, 2'd0, 0);
    pulse_ce(16'h5A5A, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_drop();
    test_load_bank2();
    test_rate();
    test_busy_drop();
    test_ignore_req();
    test_reset_mid();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
